// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: square-wave clk_o or one-cycle tick_o.
// Define CLK_DIV_PHASE_CNT_EN to add the period_cnt_o period counter output.
module clk_div_prog #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 5000,
    parameter int unsigned PHASE_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             load_i,
    output logic             load_ack_o,
    output logic             load_err_o,
    output logic             clk_o,
    output logic             tick_o,
    output logic             busy_o,
    output logic             pend_o
`ifdef CLK_DIV_PHASE_CNT_EN
    ,
    output logic [PHASE_W-1:0] period_cnt_o
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             mode_q, mode_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             ack_q, err_q;
    logic             busy_q;

    logic boundary, draining, load_ok, load_bad, rise, apply_pend;

    assign load_ok  = load_i && (div_i != '0);
    assign load_bad = load_i && (div_i == '0);
    assign draining = (state_q == StDrain) && !en_i;
    // div_act only changes on a boundary or in idle, so cnt never passes div_act-1.
    assign boundary = (state_q != StIdle) && (cnt_q == div_act_q - CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        mode_d     = mode_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        rise       = 1'b0;
        apply_pend = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (en_i) begin
                    state_d = StRun;
                    mode_d  = mode_i;
                end
            end
            StRun, StDrain: begin
                state_d    = en_i ? StRun : StDrain;
                cnt_d      = boundary ? '0 : cnt_q + CNT_W'(1);
                apply_pend = boundary;
                if (!mode_q) begin
                    if (boundary) begin
                        // Stop on the would-be rising edge so clk_o always ends low.
                        if (draining && !clk_q) begin
                            state_d = StIdle;
                        end else begin
                            clk_d = ~clk_q;
                            rise  = ~clk_q;
                        end
                    end
                end else if (draining) begin
                    state_d    = StIdle;
                    cnt_d      = '0;
                    apply_pend = 1'b1;
                end else if (boundary) begin
                    tick_d = 1'b1;
                    rise   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (apply_pend && pend_q) begin
            div_act_d = div_pend_q;
            pend_d    = 1'b0;
        end

        // A load arriving with the boundary becomes the next pending value.
        if (load_ok) begin
            if (state_q == StIdle || state_d == StIdle) begin
                div_act_d = div_i;
                pend_d    = 1'b0;
            end else begin
                div_pend_d = div_i;
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_act_q  <= CNT_W'(DEFAULT_DIV);
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            mode_q     <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            mode_q     <= mode_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            ack_q      <= load_ok;
            err_q      <= load_bad;
            busy_q     <= (state_d != StIdle);
        end
    end

    assign load_ack_o = ack_q;
    assign load_err_o = err_q;
    assign clk_o      = clk_q;
    assign tick_o     = tick_q;
    assign busy_o     = busy_q;
    assign pend_o     = pend_q;

`ifdef CLK_DIV_PHASE_CNT_EN
    logic [PHASE_W-1:0] phase_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
        end else if (state_q == StIdle && state_d == StRun) begin
            phase_q <= '0;
        end else if (rise) begin
            phase_q <= phase_q + PHASE_W'(1);
        end
    end

    assign period_cnt_o = phase_q;
`else
    logic unused_phase;
    assign unused_phase = (|PHASE_W) | rise;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: vector table for periods, scoreboard for load handshakes.
module tb_clk_div_prog;

    localparam int unsigned CNT_W = 32;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             en_i   = 1'b0;
    logic             mode_i = 1'b0;
    logic             load_i = 1'b0;
    logic [CNT_W-1:0] div_i  = '0;
    logic             load_ack_o, load_err_o, clk_o, tick_o, busy_o, pend_o;
`ifdef CLK_DIV_PHASE_CNT_EN
    logic [1:0]       period_cnt_o;
`endif

    clk_div_prog #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(5000),
        .PHASE_W    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en_i),
        .mode_i    (mode_i),
        .div_i     (div_i),
        .load_i    (load_i),
        .load_ack_o(load_ack_o),
        .load_err_o(load_err_o),
        .clk_o     (clk_o),
        .tick_o    (tick_o),
        .busy_o    (busy_o),
        .pend_o    (pend_o)
`ifdef CLK_DIV_PHASE_CNT_EN
        ,
        .period_cnt_o(period_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic ack;
        logic err;
    } hs_t;

    typedef struct {
        logic        mode;
        logic [31:0] div;
        int          first;
        int          period;
        logic        tick_next;
    } vec_t;

    hs_t hs_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        hs_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (hs_q.size() > 0 && hs_q[0].cyc == cyc) begin
            e = hs_q.pop_front();
            check("load_ack", load_ack_o, e.ack);
            check("load_err", load_err_o, e.err);
        end
    endtask

    task automatic pulse_load(input logic [CNT_W-1:0] d);
        hs_t e;
        div_i  = d;
        load_i = 1'b1;
        e.cyc  = cyc + 1;
        e.ack  = (d != 0);
        e.err  = (d == 0);
        hs_q.push_back(e);
        step();
        load_i = 1'b0;
    endtask

    task automatic do_reset();
        en_i   = 1'b0;
        load_i = 1'b0;
        mode_i = 1'b0;
        rst    = 1'b0;
        #2;
        rst    = 1'b1;
        step();
    endtask

    task automatic wait_clk_change(input int bound, output int at);
        logic s;
        s  = clk_o;
        at = -1;
        for (int k = 0; k < bound; k++) begin
            step();
            if (clk_o !== s) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   t0, at, first, second;
        logic tick_after, prev, ev, seen;
`ifdef CLK_DIV_PHASE_CNT_EN
        logic [1:0] phase_exp[5];
        phase_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif
        vecs[0] = '{mode: 1'b0, div: 3, first: 3, period: 6,  tick_next: 1'b0};
        vecs[1] = '{mode: 1'b1, div: 4, first: 4, period: 4,  tick_next: 1'b0};
        vecs[2] = '{mode: 1'b0, div: 1, first: 1, period: 2,  tick_next: 1'b0};
        vecs[3] = '{mode: 1'b1, div: 1, first: 1, period: 1,  tick_next: 1'b1};
        vecs[4] = '{mode: 1'b1, div: 7, first: 7, period: 7,  tick_next: 1'b0};
        vecs[5] = '{mode: 1'b0, div: 5, first: 5, period: 10, tick_next: 1'b0};

        // Asynchronous reset state, before any clock edge.
        #1 rst = 1'b0;
        #2;
        check("rst_ack",  load_ack_o, 0);
        check("rst_err",  load_err_o, 0);
        check("rst_clk",  clk_o, 0);
        check("rst_tick", tick_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_pend", pend_o, 0);
        rst = 1'b1;
        step();
        step();
        check("idle_busy", busy_o, 0);

        // Table of divisor/mode combinations: first event and period after RUN entry.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            pulse_load(vecs[i].div);
            mode_i = vecs[i].mode;
            en_i   = 1'b1;
            step();
            t0 = cyc;
            check($sformatf("vec%0d_busy", i), busy_o, 1);
            first      = -1;
            second     = -1;
            prev       = clk_o;
            tick_after = 1'bx;
            for (int k = 0; k < 4 * int'(vecs[i].div) + 20 && second < 0; k++) begin
                step();
                if (first >= 0 && cyc == first + 1) tick_after = tick_o;
                ev   = vecs[i].mode ? tick_o : (clk_o && !prev);
                prev = clk_o;
                if (ev) begin
                    if (first < 0) first = cyc;
                    else if (second < 0) second = cyc;
                end
            end
            check($sformatf("vec%0d_first", i), first - t0, vecs[i].first);
            check($sformatf("vec%0d_period", i), second - first, vecs[i].period);
            check($sformatf("vec%0d_tick_next", i), tick_after, vecs[i].tick_next);
        end

        // Default divisor 5000 in square mode.
        do_reset();
        en_i = 1'b1;
        step();
        t0 = cyc;
        check("def_busy", busy_o, 1);
        wait_clk_change(6000, at);
        check("def_rise1", at - t0, 5000);
        wait_clk_change(6000, at);
        check("def_fall1", at - t0, 10000);
        wait_clk_change(6000, at);
        check("def_rise2", at - t0, 15000);

        // Mid-period reload: current half-period keeps 3, later ones use 6; zero load rejected.
        do_reset();
        pulse_load(3);
        en_i = 1'b1;
        step();
        t0 = cyc;
        step();
        step();
        check("pend_pre_rise", clk_o, 0);
        step();
        check("pend_rise", clk_o, 1);
        pulse_load(6);
        check("pend_set", pend_o, 1);
        step();
        check("pend_hold", pend_o, 1);
        step();
        check("pend_clear", pend_o, 0);
        check("pend_fall3", clk_o, 0);
        wait_clk_change(20, at);
        check("pend_rise6", at - t0, 12);
        wait_clk_change(20, at);
        check("pend_fall6", at - t0, 18);
        pulse_load(0);
        check("err_no_pend", pend_o, 0);
        wait_clk_change(20, at);
        check("err_rise", at - t0, 24);
        wait_clk_change(20, at);
        check("err_fall", at - t0, 30);

        // Drain in square mode with clk_o high; zero load in idle rejected.
        do_reset();
        pulse_load(2);
        pulse_load(0);
        en_i = 1'b1;
        step();
        t0 = cyc;
        wait_clk_change(10, at);
        check("drain_rise", at - t0, 2);
        en_i = 1'b0;
        wait_clk_change(10, at);
        check("drain_fall", at - t0, 4);
        seen = 1'b0;
        for (int k = 0; k < 10 && busy_o; k++) begin
            step();
            seen |= clk_o;
        end
        check("drain_busy", busy_o, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            seen |= clk_o;
        end
        check("drain_clk_low", seen, 0);

        // Reset mid-run drops outputs without a clock edge.
        do_reset();
        pulse_load(2);
        en_i = 1'b1;
        step();
        step();
        step();
        check("mrst_pre_clk", clk_o, 1);
        pulse_load(9);
        check("mrst_pre_pend", pend_o, 1);
        rst = 1'b0;
        #2;
        check("mrst_clk",  clk_o, 0);
        check("mrst_busy", busy_o, 0);
        check("mrst_pend", pend_o, 0);
        check("mrst_ack",  load_ack_o, 0);
        check("mrst_tick", tick_o, 0);
        rst  = 1'b1;
        en_i = 1'b0;
        step();

        // Tick-mode drain: no tick after en_i drops.
        do_reset();
        pulse_load(4);
        mode_i = 1'b1;
        en_i   = 1'b1;
        step();
        for (int k = 0; k < 4; k++) step();
        check("tdrain_tick", tick_o, 1);
        en_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            seen |= tick_o;
        end
        check("tdrain_no_tick", seen, 0);
        check("tdrain_busy", busy_o, 0);

`ifdef CLK_DIV_PHASE_CNT_EN
        do_reset();
        pulse_load(1);
        mode_i = 1'b1;
        en_i   = 1'b1;
        step();
        check("phase_clr", period_cnt_o, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("phase_step%0d", k), period_cnt_o, phase_exp[k]);
        end
`endif

        check("sb_empty", hs_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
Runtime-programmable clock divider. It replaces the fixed-ratio divider, whose ratio is set at compile time.
- Generates either a square-wave divided clock-enable or a single-cycle tick from the system clock.
- Divisor is loaded through a request/acknowledge handshake.
- A new divisor is applied only on a period boundary, so the output never has a short or glitched period.
- Sits between the system clock domain and slow peripherals (LED blink, sampling strobes, UART baud base).

Parameters:
- CNT_W, 32, width of the counter and divisor.
- DEFAULT_DIV, 5000, divisor loaded at reset (10000 Hz in, 1 Hz out, half-period count).
- PHASE_W, 16, width of the period counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- en_i  in  1  run request, level-sensitive.
- mode_i  in  1  0 = square output on clk_o; 1 = tick output on tick_o. Sampled only in IDLE.
- div_i  in  CNT_W  requested divisor (half-period in square mode, full period in tick mode).
- load_i  in  1  divisor load request, one-cycle pulse.
- load_ack_o  out  1  one-cycle acknowledge when a divisor is accepted.
- load_err_o  out  1  one-cycle pulse when a load is rejected.
- clk_o  out  1  divided square output.
- tick_o  out  1  one-cycle strobe per period.
- busy_o  out  1  high while in RUN or DRAIN.
- pend_o  out  1  high while an accepted divisor waits for a boundary.

Behaviour:
- Reset (rst low, asynchronous) forces:
  - state = IDLE, cnt = 0, div_act = DEFAULT_DIV, div_pend = 0, pend_o = 0;
  - clk_o, tick_o, load_ack_o, load_err_o, busy_o all 0;
  - mode_q = 0.
- State IDLE:
  - cnt held at 0; clk_o = 0.
  - Accepted load: div_act <= div_i directly, load_ack_o pulses the next cycle, pend_o stays 0.
  - en_i = 1: go to RUN next cycle, mode_q <= mode_i, cnt starts at 0.
- State RUN:
  - cnt increments every cycle.
  - When cnt == div_act-1: cnt <= 0 (boundary).
  - Square mode: clk_o toggles at the boundary. Output period = 2*div_act cycles.
  - Tick mode: tick_o = 1 for exactly the boundary cycle. Period = div_act cycles.
  - Accepted load: div_pend <= div_i, pend_o <= 1, load_ack_o pulses the next cycle.
  - At the next boundary: div_act <= div_pend and pend_o <= 0. The new value governs the following period.
  - A second load while pend_o = 1 overwrites div_pend; last value wins, and each accepted load is acked.
  - en_i = 0: go to DRAIN.
- State DRAIN:
  - Keeps counting with the same rules.
  - Square mode: at the boundary where clk_o would rise, it stays 0 and the state goes to IDLE. clk_o never ends high.
  - Tick mode: go to IDLE immediately on the next cycle with no further tick.
  - en_i = 1 during DRAIN: return to RUN, cnt continues without restart.
  - A pending divisor is applied on entry to IDLE.
- Load rejection:
  - div_i == 0 gives load_err_o for one cycle, no ack, and no state change.
  - div_i == 1 is legal: square output toggles every cycle; tick_o is held high continuously.
- Simultaneous load_i and boundary: the boundary applies the old div_pend (if any). The new value becomes pending.
- busy_o = (state != IDLE), registered.
- Counter compare uses unsigned CNT_W arithmetic. cnt never exceeds div_act-1. If div_act changes, the compare is re-evaluated only at the boundary, so there is no wrap past 2^CNT_W-1.
- Reset mid-run: outputs drop immediately (asynchronous). The pending divisor is lost.

Optional Feature:
- Macro: CLK_DIV_PHASE_CNT_EN.
- Defined:
  - Adds output port period_cnt_o (PHASE_W bits), reset 0.
  - Increments at every boundary in RUN/DRAIN; in square mode, only on rising toggles.
  - Wraps from 2^PHASE_W-1 to 0.
  - Cleared on the IDLE-to-RUN transition.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then en_i=1 with mode 0 and default 5000 -> clk_o first rises 5000 cycles after RUN entry, period 10000; busy_o=1.
- Mode 1, load div 4 in IDLE, en_i=1 -> load_ack_o the cycle after load; tick_o on cycles 4, 8, 12 after RUN entry, each one cycle wide.
- Square mode div 3, load 6 mid-period -> pend_o=1 until the next boundary; the current half-period stays 3, subsequent half-periods are 6; pend_o returns to 0.
- load_i with div_i=0 in any state -> load_err_o one cycle, no ack, div_act unchanged, output period unchanged.
- Square mode div 2, drop en_i while clk_o=1 -> clk_o falls at the next boundary, state IDLE, busy_o=0, clk_o stays 0. Repeat with rst pulsed low mid-run -> all outputs 0 without waiting for a clock edge.
- With CLK_DIV_PHASE_CNT_EN and PHASE_W=2, tick mode div 1 for 5 cycles -> period_cnt_o steps 1,2,3,0,1.
